rf_port_arbiter: RTL



---
 rtl/rf_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rf_port_arbiter.sv
// Two-port arbiter for a shared bank of one-hot-selected tri-state registers.
// Each grant runs a fixed IDLE -> ACCESS -> RESP sequence; every output is a flop.
module rf_port_arbiter #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [AW-1:0]   p0_wa,
  input  logic [DW-1:0]   p0_wd,
  input  logic [AW-1:0]   p0_ra,
  input  logic [AW-1:0]   p0_rb,
  output logic            p0_gnt,
  output logic            p0_vld,
  output logic [DW-1:0]   p0_qa,
  output logic [DW-1:0]   p0_qb,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [AW-1:0]   p1_wa,
  input  logic [DW-1:0]   p1_wd,
  input  logic [AW-1:0]   p1_ra,
  input  logic [AW-1:0]   p1_rb,
  output logic            p1_gnt,
  output logic            p1_vld,
  output logic [DW-1:0]   p1_qa,
  output logic [DW-1:0]   p1_qb,
  output logic            busy,
  output logic [NREG-1:0] rf_en,
  output logic [NREG-1:0] rf_sela,
  output logic [NREG-1:0] rf_selb,
  output logic [DW-1:0]   rf_d,
  input  logic [DW-1:0]   rf_a,
  input  logic [DW-1:0]   rf_b
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_d;
  logic   prio;   // 1: p1 wins a tie
  logic   win;    // port that owns the current transaction
  logic   take;   // IDLE is accepting a request this cycle
  logic   sel;    // port chosen from the current requests

  logic          sel_we;
  logic [AW-1:0] sel_wa, sel_ra, sel_rb;
  logic [DW-1:0] sel_wd;

  // Addresses beyond the populated bank decode to no register at all.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    if (int'(a) < NREG) v[a] = 1'b1;
    return v;
  endfunction

  assign sel_we = sel ? p1_we : p0_we;
  assign sel_wa = sel ? p1_wa : p0_wa;
  assign sel_wd = sel ? p1_wd : p0_wd;
  assign sel_ra = sel ? p1_ra : p0_ra;
  assign sel_rb = sel ? p1_rb : p0_rb;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    take    = 1'b0;
    sel     = p1_req & (~p0_req | prio);
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          take    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      win     <= 1'b0;
      busy    <= 1'b0;
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_vld  <= 1'b0;
      p1_vld  <= 1'b0;
      p0_qa   <= '0;
      p0_qb   <= '0;
      p1_qa   <= '0;
      p1_qb   <= '0;
      rf_en   <= '0;
      rf_sela <= '0;
      rf_selb <= '0;
      rf_d    <= '0;
    end else begin
      state   <= state_d;
      busy    <= (state_d != IDLE);
      p0_gnt  <= take & ~sel;
      p1_gnt  <= take & sel;
      rf_sela <= take ? onehot(sel_ra) : '0;
      rf_selb <= take ? onehot(sel_rb) : '0;
      rf_en   <= (take && sel_we) ? onehot(sel_wa) : '0;
      rf_d    <= (take && sel_we) ? sel_wd : '0;
      p0_vld  <= (state == ACCESS) && !win;
      p1_vld  <= (state == ACCESS) && win;
      if (take) begin
        win  <= sel;
        prio <= ~sel;
      end
      // Buses are sampled at the same edge the write lands, so reads see old data.
      if (state == ACCESS) begin
        if (win) begin
          p1_qa <= rf_a;
          p1_qb <= rf_b;
        end else begin
          p0_qa <= rf_a;
          p0_qb <= rf_b;
        end
      end
    end
  end

endmodule
